muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative 32-bit multiply/divide unit with HI/LO result registers for the pipelined MIPS core. It accepts MULT, MULTU, DIV and DIVU from the EX stage and computes over multiple cycles. While it works, it raises `busy` so hazard control stalls MFHI/MFLO/MTHI/MTLO and further mul/div ops. Its `hi`/`lo` outputs feed the EX/WB result-select multiplexer as two of its data inputs.

## Interface
- `WIDTH`, 32: operand width. Only 32 is supported; the parameter exists for documentation.

- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  begin the operation in `op`; sampled only when `busy`=0.
- `op`  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `src_a`  in  32  rs operand: multiplicand or dividend.
- `src_b`  in  32  rt operand: multiplier or divisor.
- `hi_we`  in  1  MTHI write enable.
- `lo_we`  in  1  MTLO write enable.
- `wdata`  in  32  MTHI/MTLO data.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse on the cycle after results land in HI/LO.
- `hi`  out  32  HI register: product[63:32] or remainder.
- `lo`  out  32  LO register: product[31:0] or quotient.

## Operation
- FSM states:
  - IDLE to CALC on `start`. This latches the operand magnitudes, the sign flags and `op`, and clears the counter.
  - CALC runs exactly 32 iterations, counter 0..31:
    - Multiply: shift-add, one multiplier bit per cycle.
    - Divide: restoring shift-subtract, one quotient bit per cycle.
  - CALC to FIX when the counter reaches 31.
  - FIX applies sign correction, writes `hi`/`lo` and asserts `done`, then goes to IDLE.
- Signed multiply: the 64-bit magnitude product is negated when the operand signs differ.
- Signed divide:
  - The quotient is negated when the operand signs differ.
  - The remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- Unsigned ops use the raw operands; no correction is applied in FIX.
- Divide by zero (either signedness):
  - lo=0xFFFFFFFF, hi=`src_a` as latched.
  - Same latency as a normal divide; no exception is raised.
- `busy` = (state != IDLE). `done` is registered and high only in the cycle after FIX.
- `start` while `busy`=1 is ignored. Hazard control must not issue it; the block does not queue it.
- `hi_we`/`lo_we` while `busy`=1 are ignored.
- `hi_we`/`lo_we` while IDLE write `wdata` to the selected register(s) at that edge.
- `start` and a write in the same IDLE cycle: both take effect. The write lands now; the op result overwrites it at FIX.
- Operands are captured at the start edge. Later changes on `src_a`/`src_b` have no effect.

## Timing
- Reset (`rst_n`=0 at a rising edge): state=IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter=0.
- Reset mid-operation aborts the op immediately. No partial result is written.
- The start edge is E0:
  - `busy`=1 after E0.
  - Iterations happen at E1..E32.
  - FIX happens at E33: `hi`/`lo` updated and `busy`=0 after E33.
  - `done`=1 during the cycle following E33.
- A new `start` is accepted at E33+1 at the earliest; there are no back-to-back gaps beyond that.
- `hi`/`lo` hold their previous values for the whole operation.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - MULT/MULTU use a single-cycle 32x32 array multiply.
  - The result is written at E1.
  - `busy` is high for the one cycle between E0 and E1.
  - `done` pulses in the cycle after E1.
- `MULDIV_FAST_MUL_EN` not defined: multiplies use the 33-edge iterative path.
- Divides are always iterative and identical in both builds.

## Test plan
- Reset with stale HI/LO, then `rst_n`=0 for one edge: `hi`=`lo`=0, `busy`=0, `done`=0.
- MULT 0xFFFFFFFE × 0x00000003 → hi=0xFFFFFFFF, lo=0xFFFFFFFA, `busy` high 33 cycles, one `done` pulse. MULTU with the same operands → hi=0x00000002, lo=0xFFFFFFFA.
- DIV 0xFFFFFFF9 (−7) / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 → lo=14, hi=2. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU 0x1234 / 0 → lo=0xFFFFFFFF, hi=0x00001234 after 33 edges.
- During an op, toggle operands, pulse `start` and `hi_we` with `wdata`=0xDEADBEEF → all ignored and the result is unchanged. After completion, `lo_we` with 0xCAFEF00D → lo=0xCAFEF00D at the next edge.
- `rst_n`=0 at E10 of a DIV → `busy`=0, hi=lo=0, no `done`. With `MULDIV_FAST_MUL_EN` built in, MULTU 0x10000 × 0x10000 → hi=1, lo=0, `busy` high 1 cycle.

Source files
------------

// File: rtl/muldiv_if.sv
// EX-stage to multiply/divide unit bus: op issue, MTHI/MTLO writes, HI/LO results.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, src_a, src_b, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, src_a, src_b, hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU with HI/LO registers.
// Define MULDIV_FAST_MUL_EN for a single-cycle array multiply; divides stay iterative.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input logic     clk,
  input logic     rst_n,
  muldiv_if.slave bus
);
  // state | meaning
  // IDLE  | waiting for start, MTHI/MTLO writes accepted
  // CALC  | one shift-add or shift-subtract iteration per cycle, cnt 0..31
  // FIX   | sign correction, HI/LO write, done raised for the next cycle
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   work_hi;
  logic [WIDTH-1:0]   work_lo;
  logic               neg_a;
  logic               neg_b;
  logic [1:0]         op_q;
  logic [4:0]         cnt;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic               sgn_in;
  logic               neg_a_in;
  logic               neg_b_in;
  logic [WIDTH-1:0]   mag_a_in;
  logic [WIDTH-1:0]   mag_b_in;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh;
  logic               div_ge;
  logic [WIDTH-1:0]   div_sub;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   a_raw;
`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;
  assign fast_prod = {{WIDTH{1'b0}}, mag_a_in} * {{WIDTH{1'b0}}, mag_b_in};
`endif

  // Sign flags are only ever set for signed ops, so unsigned results pass FIX untouched.
  assign sgn_in   = ~bus.op[0];
  assign neg_a_in = sgn_in & bus.src_a[WIDTH-1];
  assign neg_b_in = sgn_in & bus.src_b[WIDTH-1];
  assign mag_a_in = neg_a_in ? -bus.src_a : bus.src_a;
  assign mag_b_in = neg_b_in ? -bus.src_b : bus.src_b;

  assign mul_sum  = {1'b0, work_hi} + (work_lo[0] ? {1'b0, mag_a} : {(WIDTH+1){1'b0}});
  assign div_sh   = {work_hi, work_lo[WIDTH-1]};
  assign div_ge   = div_sh >= {1'b0, mag_b};
  // When div_ge holds the difference is below the divisor, so 32 bits are exact.
  assign div_sub  = div_sh[WIDTH-1:0] - mag_b;

  assign prod_fix = (neg_a ^ neg_b) ? -{work_hi, work_lo} : {work_hi, work_lo};
  assign quo_fix  = (neg_a ^ neg_b) ? -work_lo : work_lo;
  assign rem_fix  = neg_a ? -work_hi : work_hi;
  assign a_raw    = neg_a ? -mag_a : mag_a;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      mag_a   <= '0;
      mag_b   <= '0;
      work_hi <= '0;
      work_lo <= '0;
      neg_a   <= 1'b0;
      neg_b   <= 1'b0;
      op_q    <= 2'b00;
      cnt     <= 5'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.hi_we) hi_q <= bus.wdata;
          if (bus.lo_we) lo_q <= bus.wdata;
          if (bus.start) begin
            mag_a   <= mag_a_in;
            mag_b   <= mag_b_in;
            neg_a   <= neg_a_in;
            neg_b   <= neg_b_in;
            op_q    <= bus.op;
            cnt     <= 5'd0;
            busy_q  <= 1'b1;
            work_hi <= '0;
            // Multiply shifts the multiplier out of work_lo; divide shifts the dividend out.
            work_lo <= bus.op[1] ? mag_a_in : mag_b_in;
            state   <= CALC;
`ifdef MULDIV_FAST_MUL_EN
            if (!bus.op[1]) begin
              {work_hi, work_lo} <= fast_prod;
              state              <= FIX;
            end
`endif
          end
        end
        CALC: begin
          if (op_q[1]) begin
            work_hi <= div_ge ? div_sub : div_sh[WIDTH-1:0];
            work_lo <= {work_lo[WIDTH-2:0], div_ge};
          end else begin
            work_hi <= mul_sum[WIDTH:1];
            work_lo <= {mul_sum[0], work_lo[WIDTH-1:1]};
          end
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= FIX;
        end
        FIX: begin
          if (op_q[1]) begin
            if (mag_b == '0) begin
              hi_q <= a_raw;
              lo_q <= '1;
            end else begin
              hi_q <= rem_fix;
              lo_q <= quo_fix;
            end
          end else begin
            {hi_q, lo_q} <= prod_fix;
          end
          done_q <= 1'b1;
          busy_q <= 1'b0;
          cnt    <= 5'd0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized bench for muldiv_unit against an arithmetic reference of HI/LO.
module tb_muldiv_unit;
  logic clk;
  logic rst_n;
  int   errs;
  int   checks;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  muldiv_if #(.WIDTH(32)) bus ();

  muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'b00: res = sa * sb;
      2'b01: res = {32'd0, a} * {32'd0, b};
      2'b10: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else res = {a % b, a / b};
      end
    endcase
    return res;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit disturb);
    logic [63:0] r;
    int cyc;
    int lat;
    bit early_done;
    r   = ref_model(o, a, b);
    lat = 33;
`ifdef MULDIV_FAST_MUL_EN
    if (!o[1]) lat = 1;
`endif
    bus.op = o;
    bus.src_a = a;
    bus.src_b = b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("busy_after_start", {63'd0, bus.busy}, 64'd1);
    cyc = 0;
    early_done = 1'b0;
    while (bus.busy && cyc < 100) begin
      if (disturb && cyc == 4) begin
        bus.src_a = $urandom;
        bus.src_b = $urandom;
        bus.op    = 2'($urandom_range(0, 3));
        bus.start = 1'b1;
        bus.hi_we = 1'b1;
        bus.wdata = 32'hDEAD_BEEF;
      end else if (disturb && cyc == 5) begin
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
      end
      tick();
      cyc++;
      if (bus.busy && bus.done) early_done = 1'b1;
      if (cyc == 10 && bus.busy) check("hold_during_op", {bus.hi, bus.lo}, {exp_hi, exp_lo});
    end
    check("latency", 64'(cyc), 64'(lat));
    check("no_done_while_busy", {63'd0, early_done}, 64'd0);
    check("done_pulse", {63'd0, bus.done}, 64'd1);
    check("result", {bus.hi, bus.lo}, r);
    {exp_hi, exp_lo} = r;
    tick();
    check("done_cleared", {63'd0, bus.done}, 64'd0);
  endtask

  initial begin
    logic [1:0]  o;
    logic [31:0] a, b;
    int          dcount;
    errs = 0;
    checks = 0;
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    bus.start = 1'b0;
    bus.op = 2'b00;
    bus.src_a = 32'd0;
    bus.src_b = 32'd0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = 32'd0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    // Stale HI/LO via MTHI/MTLO, then a one-edge reset
    bus.hi_we = 1'b1;
    bus.lo_we = 1'b1;
    bus.wdata = 32'h5555_AAAA;
    tick();
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    check("mt_write", {bus.hi, bus.lo}, {32'h5555_AAAA, 32'h5555_AAAA});
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("reset_hilo", {bus.hi, bus.lo}, 64'd0);
    check("reset_busy_done", {62'd0, bus.busy, bus.done}, 64'd0);

    run_op(2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0);
    check("mult_neg", {bus.hi, bus.lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFA});
    run_op(2'b01, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0);
    check("multu", {bus.hi, bus.lo}, {32'h0000_0002, 32'hFFFF_FFFA});
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("div_neg", {bus.hi, bus.lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op(2'b11, 32'd100, 32'd7, 1'b0);
    check("divu", {bus.hi, bus.lo}, {32'd2, 32'd14});
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("div_ovf", {bus.hi, bus.lo}, {32'd0, 32'h8000_0000});
    run_op(2'b11, 32'h0000_1234, 32'd0, 1'b0);
    check("divu_zero", {bus.hi, bus.lo}, {32'h0000_1234, 32'hFFFF_FFFF});
    run_op(2'b10, 32'hFFFF_FF00, 32'd0, 1'b0);
    check("div_zero_neg", {bus.hi, bus.lo}, {32'hFFFF_FF00, 32'hFFFF_FFFF});
    run_op(2'b01, 32'h0001_0000, 32'h0001_0000, 1'b0);
    check("multu_2_32", {bus.hi, bus.lo}, {32'd1, 32'd0});

    // Operand/start/MTHI disturbance during a divide must be ignored
    run_op(2'b10, 32'h7654_3210, 32'hFFFF_F001, 1'b1);
    bus.lo_we = 1'b1;
    bus.wdata = 32'hCAFE_F00D;
    tick();
    bus.lo_we = 1'b0;
    exp_lo = 32'hCAFE_F00D;
    check("mtlo_after", {bus.hi, bus.lo}, {exp_hi, exp_lo});

    // Start and MTHI in the same idle cycle: result wins at FIX
    bus.hi_we = 1'b1;
    bus.wdata = 32'h1111_2222;
    bus.op = 2'b11;
    bus.src_a = 32'd50;
    bus.src_b = 32'd8;
    bus.start = 1'b1;
    tick();
    bus.hi_we = 1'b0;
    bus.start = 1'b0;
    check("same_cycle_write", {32'd0, bus.hi}, {32'd0, 32'h1111_2222});
    for (int i = 0; i < 40 && bus.busy; i++) tick();
    check("same_cycle_result", {bus.hi, bus.lo}, {32'd2, 32'd6});
    tick();
    {exp_hi, exp_lo} = {32'd2, 32'd6};

    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: a = 32'($urandom_range(0, 1000));
        default: ;
      endcase
      run_op(o, a, b, 1'b0);
    end

    // Reset at E10 of a divide aborts it with no done pulse
    bus.op = 2'b10;
    bus.src_a = 32'h0BAD_F00D;
    bus.src_b = 32'd3;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
    check("abort_hilo", {bus.hi, bus.lo}, 64'd0);
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done) dcount++;
    end
    check("abort_no_done", 64'(dcount), 64'd0);
    check("abort_hilo_late", {bus.hi, bus.lo}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
